// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// Holds the FSM state enum, ACK/NACK bus levels and bit-counter width.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int   BITCNT_W = 3;

endpackage

// File: rtl/i2c_slave_if.sv
// Host-side data interface of the I2C target.
// tx_data: byte to return on reads; rx_data/rx_valid: received write bytes;
// rd_req: tx_data captured; busy: addressed transfer in progress.
interface i2c_slave_if;

    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_req;
    logic       busy;

    modport slave (
        input  tx_data,
        output rx_data,
        output rx_valid,
        output rd_req,
        output busy
    );

    modport master (
        output tx_data,
        input  rx_data,
        input  rx_valid,
        input  rd_req,
        input  busy
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and decodes bus events.
// Ports: clk, rst (sync, active-high), scl/sda pins in; synced levels
// scl_s/sda_s and registered one-cycle events scl_rise, scl_fall, start, stop.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_q;
    logic [SYNC_STAGES-1:0] sda_q;
    logic                   scl_p;
    logic                   sda_p;
    logic                   scl_hold;

    assign scl_s    = scl_q[SYNC_STAGES-1];
    assign sda_s    = sda_q[SYNC_STAGES-1];
    // An SDA edge only counts as START/STOP when SCL is steadily high,
    // so a same-cycle SCL change always wins.
    assign scl_hold = scl_s & scl_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q    <= '1;
            sda_q    <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_q    <= {scl_q[SYNC_STAGES-2:0], scl};
            sda_q    <= {sda_q[SYNC_STAGES-2:0], sda};
            scl_p    <= scl_s;
            sda_p    <= sda_s;
            scl_rise <= scl_s & ~scl_p;
            scl_fall <= ~scl_s & scl_p;
            start    <= scl_hold & sda_p & ~sda_s;
            stop     <= scl_hold & ~sda_p & sda_s;
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target: address match, write receive, read transmit.
// Ports: clk, rst (sync, active-high), scl in, sda open-drain inout,
// bus (i2c_slave_if.slave) carrying tx_data, rx_data, rx_valid, rd_req, busy.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    inout  wire           sda,
    i2c_slave_if.slave    bus
);

    logic scl_s, sda_s, scl_rise, scl_fall, start, stop;
    logic rise, fall;

    i2c_state_e          state;
    logic [BITCNT_W-1:0] bitcnt;
    logic [7:0]          shift;
    logic [7:0]          shift_nx;
    logic                rw;
    logic                sda_oe;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // Drop an edge whose new level did not persist for a second cycle.
    assign rise     = scl_rise & scl_s;
    assign fall     = scl_fall & ~scl_s;
    assign shift_nx = {shift[6:0], sda_s};

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shift        <= '0;
            rw           <= 1'b0;
            sda_oe       <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.rd_req   <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            bus.rd_req   <= 1'b0;
            if (start) begin
                state  <= ADDR;
                bitcnt <= '0;
                shift  <= '0;
                sda_oe <= 1'b0;
            end else if (stop) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (rise) begin
                        shift  <= shift_nx;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            if (shift_nx[7:1] == SLAVE_ADDR) begin
                                state    <= ADDR_ACK;
                                rw       <= shift_nx[0];
                                bus.busy <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    // sda_oe doubles as the phase flag of an ACK slot:
                    // first fall starts the ACK, second fall ends it.
                    ADDR_ACK: if (fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw) begin
                            shift      <= bus.tx_data;
                            sda_oe     <= ~bus.tx_data[7];
                            bus.rd_req <= 1'b1;
                            bitcnt     <= '0;
                            state      <= RD_DATA;
                        end else begin
                            sda_oe <= 1'b0;
                            bitcnt <= '0;
                            state  <= WR_DATA;
                        end
                    end
                    WR_DATA: if (rise) begin
                        shift  <= shift_nx;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            bus.rx_data  <= shift_nx;
                            bus.rx_valid <= 1'b1;
                            state        <= WR_ACK;
                        end
                    end
                    WR_ACK: if (fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= WR_DATA;
                        end
                    end
                    RD_DATA: if (fall) begin
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            sda_oe <= 1'b0;
                            state  <= RD_ACK;
                        end else begin
                            shift  <= {shift[6:0], 1'b0};
                            sda_oe <= ~shift[6];
                        end
                    end
                    // A NACK leaves on the rise, so any fall seen here
                    // follows an ACK.
                    RD_ACK: begin
                        if (rise && sda_s == I2C_NACK) begin
                            state <= WAIT_STOP;
                        end else if (fall) begin
                            shift      <= bus.tx_data;
                            sda_oe     <= ~bus.tx_data[7];
                            bus.rd_req <= 1'b1;
                            bitcnt     <= '0;
                            state      <= RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-bang master BFM on a pulled-up
// bus with a transaction-level model of written and read bytes.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int         Q    = 10;
    localparam logic [6:0] ADDR = 7'h50;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic scl  = 1'b1;
    logic m_oe = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    i2c_slave_if ifc ();

    i2c_slave #(
        .SLAVE_ADDR  (ADDR),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda),
        .bus (ifc)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_mem [64];
    int         rd_ptr = 0;
    logic [7:0] got_rx [$];
    int         rdreq_cnt = 0;
    int         dut_low   = 0;
    int         clash     = 0;
    logic [7:0] last_rx   = 8'h00;

    assign ifc.tx_data = tx_mem[rd_ptr[5:0]];

    always @(negedge clk) begin
        if (ifc.rx_valid) got_rx.push_back(ifc.rx_data);
        if (ifc.rd_req) begin
            rdreq_cnt <= rdreq_cnt + 1;
            rd_ptr    <= rd_ptr + 1;
        end
        if (ifc.rd_req && ifc.rx_valid) clash <= clash + 1;
        if (!m_oe && sda === 1'b0) dut_low <= dut_low + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_oe = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        m_oe = 1'b1; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        m_oe = 1'b0; tick(4);
        chk("busy_after_stop", {31'd0, ifc.busy}, 32'd0);
        tick(2 * Q);
    endtask

    task automatic wr_bit(input logic b);
        m_oe = ~b;   tick(Q);
        scl  = 1'b1; tick(2 * Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic rd_bit(output logic b);
        m_oe = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        b    = (sda === 1'b0) ? 1'b0 : 1'b1;
        tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(ack);
    endtask

    // Write n bytes (first given, rest random) to address a; a target
    // at ADDR must ACK and deliver each byte once, any other stays quiet.
    task automatic xfer_write(input logic [6:0] a, input logic [7:0] first,
                              input int n);
        logic       ack;
        logic       match;
        logic [7:0] d;
        logic [7:0] exp [$];
        int         rx0, low0;
        rx0   = got_rx.size();
        low0  = dut_low;
        match = (a == ADDR);
        bus_start();
        wr_byte({a, 1'b0}, ack);
        chk("addr_ack", {31'd0, ack}, {31'd0, match ? I2C_ACK : I2C_NACK});
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? first : 8'($urandom);
            wr_byte(d, ack);
            chk("data_ack", {31'd0, ack},
                {31'd0, match ? I2C_ACK : I2C_NACK});
            if (match) exp.push_back(d);
        end
        chk("busy_in_xfer", {31'd0, ifc.busy}, {31'd0, match});
        bus_stop();
        chk("rx_count", got_rx.size() - rx0, exp.size());
        for (int k = 0; k < exp.size(); k++)
            chk("rx_byte", {24'd0, got_rx[rx0 + k]}, {24'd0, exp[k]});
        if (match) last_rx = exp[exp.size() - 1];
        else chk("dut_quiet", dut_low - low0, 32'd0);
        chk("rx_data_hold", {24'd0, ifc.rx_data}, {24'd0, last_rx});
    endtask

    // Read n bytes, ACKing all but the last; expected bytes are the
    // ones queued in tx_mem before the transfer.
    task automatic xfer_read(input int n, input logic [7:0] first);
        logic       ack;
        logic [7:0] d;
        int         rq0, p0, low1;
        rq0 = rdreq_cnt;
        p0  = rd_ptr;
        for (int k = 0; k < n; k++)
            tx_mem[(p0 + k) % 64] = (k == 0) ? first : 8'($urandom);
        bus_start();
        wr_byte({ADDR, 1'b1}, ack);
        chk("rd_addr_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        for (int k = 0; k < n; k++) begin
            rd_byte(d, (k == n - 1) ? I2C_NACK : I2C_ACK);
            chk("rd_byte", {24'd0, d}, {24'd0, tx_mem[(p0 + k) % 64]});
        end
        low1 = dut_low;
        chk("busy_in_read", {31'd0, ifc.busy}, 32'd1);
        bus_stop();
        chk("nack_release", dut_low - low1, 32'd0);
        chk("rd_req_count", rdreq_cnt - rq0, n);
    endtask

    initial begin
        logic       ack;
        logic [6:0] bad;
        int         rx0;

        tick(3);
        chk("rst_rx_data", {24'd0, ifc.rx_data}, 32'd0);
        chk("rst_flags", {29'd0, ifc.rx_valid, ifc.rd_req, ifc.busy}, 32'd0);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        rst = 1'b0;
        tick(5);

        xfer_write(ADDR, 8'hA5, 1);
        xfer_read(1, 8'h3C);
        xfer_write(7'h51, 8'h5A, 1);
        xfer_write(ADDR, 8'h11, 2);

        // STOP inside a byte discards it.
        rx0 = got_rx.size();
        bus_start();
        wr_byte({ADDR, 1'b0}, ack);
        chk("part_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        for (int i = 0; i < 4; i++) wr_bit(1'b1);
        bus_stop();
        chk("part_no_rx", got_rx.size() - rx0, 32'd0);
        chk("part_rx_data", {24'd0, ifc.rx_data}, {24'd0, last_rx});

        // Repeated START abandons a partial write and serves a read.
        bus_start();
        wr_byte({ADDR, 1'b0}, ack);
        wr_bit(1'b0);
        wr_bit(1'b1);
        xfer_read(2, 8'($urandom));
        chk("rs_no_rx", got_rx.size() - rx0, 32'd0);

        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 2))
                0: xfer_write(ADDR, 8'($urandom), $urandom_range(1, 3));
                1: xfer_read($urandom_range(1, 3), 8'($urandom));
                default: begin
                    do bad = 7'($urandom); while (bad == ADDR);
                    xfer_write(bad, 8'($urandom), 1);
                end
            endcase
        end

        // Reset while the target holds a 0 read bit on the bus.
        tx_mem[rd_ptr % 64] = 8'($urandom) & 8'h7F;
        bus_start();
        wr_byte({ADDR, 1'b1}, ack);
        chk("pre_rst_drive", {31'd0, sda}, 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_release", {31'd0, sda}, 32'd1);
        chk("rst_mid_rx", {24'd0, ifc.rx_data}, 32'd0);
        chk("rst_mid_flags", {29'd0, ifc.rx_valid, ifc.rd_req, ifc.busy},
            32'd0);
        last_rx = 8'h00;
        bus_stop();
        xfer_write(ADDR, 8'($urandom), 1);

        chk("valid_req_clash", clash, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
